mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one native-interface memory slave.
- Native interface signals: valid, instr, ready, addr, wdata, wstrb, rdata.
- Requester m0 is the picorv32 core. Requester m1 is a secondary master: a DMA engine or a bench/debug loader.
- Grant policy is round-robin. Each transaction is locked until the slave returns ready.
- A watchdog terminates hung slave accesses. Per-master saturating transaction counters support test reporting.

Parameters:
- TIMEOUT, 64: max cycles s_valid may stay high without s_ready before forced termination; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned to a master on a timed-out read.
- CNT_W, 16: width of the per-master transaction counters.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  core request.
- m0_instr  in  1  core fetch flag.
- m0_addr  in  32  core address.
- m0_wdata  in  32  core write data.
- m0_wstrb  in  4  core byte strobes; 0 means read.
- m0_ready  out  1  one-cycle completion pulse to the core.
- m0_rdata  out  32  read data to the core; valid while m0_ready is high.
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0, for the secondary master.
- s_valid  out  1  request to the slave.
- s_instr  out  1  forwarded fetch flag.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_wstrb  out  4  forwarded byte strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- owner  out  2  2'b00 none, 2'b01 m0, 2'b10 m1.
- timeout_err  out  1  sticky; set on any watchdog termination.
- m0_count  out  CNT_W  completed m0 transactions, saturating.
- m1_count  out  CNT_W  completed m1 transactions, saturating.

Behaviour:
- Reset values: state IDLE, owner 0, s_valid 0, s_instr/s_addr/s_wdata/s_wstrb 0, m*_ready 0, m*_rdata 0, timeout_err 0, counters 0, watchdog 0, rr_last = m1 (so m0 wins the first tie).
- Reset asserted mid-transaction aborts it immediately. No ready pulse is issued. The slave sees s_valid low the next cycle.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Both valid: grant the master that is not rr_last.
  - One valid: grant it.
  - Register owner and go to BUSY.
  - Arbitration latency: 1 cycle from m*_valid to s_valid.
- BUSY:
  - s_valid = 1. s_instr/s_addr/s_wdata/s_wstrb are combinational muxes of the owner's inputs. Masters hold these stable until ready.
  - Watchdog increments each BUSY cycle.
  - On s_ready: assert owner's m*_ready for exactly 1 cycle, combinational in the same cycle as s_ready.
  - m*_rdata = s_rdata in that cycle. Non-owner m*_ready stays 0 and its m*_rdata is 0.
  - Then: increment the owner's counter (hold at all-ones), set rr_last = owner, clear the watchdog, go to DONE.
- BUSY timeout:
  - If the watchdog reaches TIMEOUT-1 and s_ready is still 0 in that cycle: pulse the owner's m*_ready with m*_rdata = ERR_RDATA.
  - Drop s_valid, set timeout_err, go to DONE. The counter is not incremented.
  - s_ready in that same cycle takes priority over the timeout: normal completion, no error.
- DONE:
  - One cycle, with s_valid = 0 and owner = 0. This lets the master drop valid after ready.
  - Always returns to IDLE. Back-to-back requests from one master therefore complete at best every 3 cycles.
- s_ready while not in BUSY is ignored.
- A master deasserting valid during BUSY is a protocol violation; the transaction completes anyway.
- Fairness: with both masters continuously requesting, grants strictly alternate.
- timeout_err clears only on reset.

Test Plan:
- m0-only store then load:
  - Stimulus: m0 SW addr 0x100 data 0xFF, wstrb 4'hF; then LW 0x100 against a 1-cycle-latency memory.
  - Required: s_valid 1 cycle after m0_valid; m0_ready pulse 1 cycle; m0_rdata = 0x000000FF; m0_count = 2; owner returns to 0 in DONE.
- Simultaneous requests after reset:
  - Stimulus: m0_valid = m1_valid = 1 in the same cycle.
  - Required: m0 granted first, m1 next. Continued contention for 6 transactions gives owner sequence 01,10,01,10,01,10; m0_count = m1_count = 3.
- Byte-strobe passthrough:
  - Stimulus: m1 write wstrb 4'b0100, data 0x00AA0000 to 0x104.
  - Required: s_wstrb = 4'b0100 and s_addr = 0x104 exactly while BUSY; m0_ready stays 0.
- Hung slave:
  - Stimulus: s_ready tied 0, TIMEOUT = 8, m0 read.
  - Required: m0_ready pulses 8 cycles after s_valid rises; m0_rdata = 0xDEADBEEF; timeout_err = 1 and stays set; m0_count unchanged.
  - Also: s_ready arriving in the 8th cycle gives a normal completion with timeout_err = 0.
- Reset mid-transaction:
  - Stimulus: assert reset while BUSY, with s_ready held 0.
  - Required: next cycle s_valid = 0, owner = 0, no m*_ready pulse, counters = 0.
- Counter saturation:
  - Setup: CNT_W = 4.
  - Stimulus: 20 m0 transactions.
  - Required: m0_count holds at 15.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting two native-interface masters share one memory slave.
// A watchdog ends hung slave accesses; saturating counters tally completed transactions.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_valid,
  input  logic             m0_instr,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic             m0_ready,
  output logic [31:0]      m0_rdata,
  input  logic             m1_valid,
  input  logic             m1_instr,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic             m1_ready,
  output logic [31:0]      m1_rdata,
  output logic             s_valid,
  output logic             s_instr,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_wstrb,
  input  logic             s_ready,
  input  logic [31:0]      s_rdata,
  output logic [1:0]       owner,
  output logic             timeout_err,
  output logic [CNT_W-1:0] m0_count,
  output logic [CNT_W-1:0] m1_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0]       OWN_NONE  = 2'b00;
  localparam logic [1:0]       OWN_M0    = 2'b01;
  localparam logic [1:0]       OWN_M1    = 2'b10;
  localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       rr_last_q;
  logic [15:0]      wdog_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] m0_count_q;
  logic [CNT_W-1:0] m1_count_q;

  logic [1:0]       grant_d;
  logic [CNT_W-1:0] m0_count_d;
  logic [CNT_W-1:0] m1_count_d;
  logic             busy_s;
  logic             ok_s;
  logic             tmo_s;
  logic             fin_s;

  // A reset cycle never completes a transaction, so no ready pulse escapes it.
  assign busy_s = (state_q == BUSY);
  assign ok_s   = busy_s && s_ready && !reset;
  assign tmo_s  = busy_s && !s_ready && !reset && (wdog_q == WDOG_LAST);
  assign fin_s  = ok_s || tmo_s;

  assign m0_count_d = (m0_count_q == CNT_MAX) ? m0_count_q : (m0_count_q + CNT_ONE);
  assign m1_count_d = (m1_count_q == CNT_MAX) ? m1_count_q : (m1_count_q + CNT_ONE);

  // Round-robin grant: on a tie the master that did not go last wins.
  always_comb begin
    grant_d = OWN_NONE;
    if (m0_valid && m1_valid) begin
      if (rr_last_q == OWN_M0) begin
        grant_d = OWN_M1;
      end else begin
        grant_d = OWN_M0;
      end
    end else if (m0_valid) begin
      grant_d = OWN_M0;
    end else if (m1_valid) begin
      grant_d = OWN_M1;
    end else begin
      grant_d = OWN_NONE;
    end
  end

  // Forward the owner's request to the slave and steer the completion back.
  always_comb begin
    s_instr  = 1'b0;
    s_addr   = 32'h0000_0000;
    s_wdata  = 32'h0000_0000;
    s_wstrb  = 4'h0;
    m0_ready = 1'b0;
    m0_rdata = 32'h0000_0000;
    m1_ready = 1'b0;
    m1_rdata = 32'h0000_0000;
    if (busy_s) begin
      if (owner_q == OWN_M1) begin
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end else begin
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
    end else begin
      s_instr = 1'b0;
    end
    if (fin_s) begin
      case (owner_q)
        OWN_M0: begin
          m0_ready = 1'b1;
          m0_rdata = tmo_s ? ERR_RDATA : s_rdata;
        end
        OWN_M1: begin
          m1_ready = 1'b1;
          m1_rdata = tmo_s ? ERR_RDATA : s_rdata;
        end
        default: begin
          m0_ready = 1'b0;
          m1_ready = 1'b0;
        end
      endcase
    end else begin
      m0_ready = 1'b0;
    end
  end

  assign s_valid     = busy_s;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;
  assign m0_count    = m0_count_q;
  assign m1_count    = m1_count_q;

  // Arbitration FSM, watchdog, sticky error flag and completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_NONE;
      rr_last_q     <= OWN_M1;
      wdog_q        <= 16'd0;
      timeout_err_q <= 1'b0;
      m0_count_q    <= {CNT_W{1'b0}};
      m1_count_q    <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= 16'd0;
          if (grant_d != OWN_NONE) begin
            owner_q <= grant_d;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (ok_s) begin
            if (owner_q == OWN_M1) begin
              m1_count_q <= m1_count_d;
            end else begin
              m0_count_q <= m0_count_d;
            end
            rr_last_q <= owner_q;
            owner_q   <= OWN_NONE;
            wdog_q    <= 16'd0;
            state_q   <= DONE;
          end else if (tmo_s) begin
            // The aborted grant still counts as a turn, so fairness survives a hung slave.
            rr_last_q     <= owner_q;
            owner_q       <= OWN_NONE;
            wdog_q        <= 16'd0;
            timeout_err_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors and sequences plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          s_valid, s_instr, s_ready;
  logic [31:0]   s_addr, s_wdata, s_rdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    owner;
  logic          timeout_err;
  logic [CW-1:0] m0_count, m1_count;

  mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .timeout_err(timeout_err), .m0_count(m0_count), .m1_count(m1_count)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  // Reference model: who holds the slave, for how long, and the bookkeeping.
  int  mdl_own;   // 0 none, 1 m0, 2 m1
  int  mdl_age;
  bit  mdl_cool;
  int  mdl_last;
  bit  mdl_err;
  int  mdl_cnt[2];

  // Slave model
  logic [31:0] mem [0:255];
  int  lat_cur = 0;
  bit  hang = 1'b0;
  int  svc_cnt = 0;

  logic        smp_ready[2];
  logic [31:0] smp_rdata[2];
  logic        smp_sv;
  logic [1:0]  smp_owner;
  logic [31:0] smp_addr;
  logic [3:0]  smp_wstrb;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [1:0] e_owner;
    logic       e_r0;
    logic       e_r1;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_own = 0; mdl_age = 0; mdl_cool = 1'b0; mdl_last = 2; mdl_err = 1'b0;
    mdl_cnt[0] = 0; mdl_cnt[1] = 0;
  endtask

  task automatic drive_m(input int m, input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  // One clock cycle: slave reacts, outputs are checked, then the edge advances the model.
  task automatic run_cycle();
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    logic [3:0]  e_wstrb;
    logic        e_instr, e_fin, e_tmo;
    int          g;
    #1;
    if (s_valid === 1'b1) begin
      s_ready = !hang && (svc_cnt >= lat_cur);
      s_rdata = s_ready ? mem[s_addr[9:2]] : $urandom;
    end else begin
      s_ready = 1'($urandom_range(0, 1));
      s_rdata = $urandom;
    end
    #1;
    e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0; e_instr = 1'b0;
    if (mdl_own == 1) begin
      e_addr = m0_addr; e_wdata = m0_wdata; e_wstrb = m0_wstrb; e_instr = m0_instr;
    end else if (mdl_own == 2) begin
      e_addr = m1_addr; e_wdata = m1_wdata; e_wstrb = m1_wstrb; e_instr = m1_instr;
    end
    e_fin = (mdl_own != 0) && !reset && (s_ready || mdl_age == TO - 1);
    e_tmo = e_fin && !s_ready;
    e_rd0 = (e_fin && mdl_own == 1) ? (e_tmo ? 32'hDEAD_BEEF : s_rdata) : 32'h0;
    e_rd1 = (e_fin && mdl_own == 2) ? (e_tmo ? 32'hDEAD_BEEF : s_rdata) : 32'h0;
    chk("s_valid", {31'd0, s_valid}, {31'd0, mdl_own != 0});
    chk("owner", {30'd0, owner}, (mdl_own == 1) ? 32'd1 : (mdl_own == 2) ? 32'd2 : 32'd0);
    chk("s_addr", s_addr, e_addr);
    chk("s_wdata", s_wdata, e_wdata);
    chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, e_wstrb});
    chk("s_instr", {31'd0, s_instr}, {31'd0, e_instr});
    chk("m0_ready", {31'd0, m0_ready}, {31'd0, e_fin && mdl_own == 1});
    chk("m1_ready", {31'd0, m1_ready}, {31'd0, e_fin && mdl_own == 2});
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, mdl_err});
    chk("m0_count", {28'd0, m0_count}, mdl_cnt[0]);
    chk("m1_count", {28'd0, m1_count}, mdl_cnt[1]);
    smp_ready[0] = m0_ready; smp_ready[1] = m1_ready;
    smp_rdata[0] = m0_rdata; smp_rdata[1] = m1_rdata;
    smp_sv = s_valid; smp_owner = owner; smp_addr = s_addr; smp_wstrb = s_wstrb;
    @(posedge clk);
    if (mdl_own != 0 && s_ready && !reset) begin
      for (int b = 0; b < 4; b++)
        if (e_wstrb[b]) mem[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
    end
    if (reset) svc_cnt = 0;
    else if (smp_sv && !s_ready) svc_cnt = svc_cnt + 1;
    else svc_cnt = 0;
    if (reset) begin
      model_reset();
    end else if (e_fin) begin
      if (e_tmo) mdl_err = 1'b1;
      else if (mdl_cnt[mdl_own-1] < (1 << CW) - 1) mdl_cnt[mdl_own-1]++;
      mdl_last = mdl_own; mdl_own = 0; mdl_cool = 1'b1;
    end else if (mdl_own != 0) begin
      mdl_age++;
    end else if (mdl_cool) begin
      mdl_cool = 1'b0;
    end else begin
      if (m0_valid && m1_valid) g = (mdl_last == 1) ? 2 : 1;
      else if (m0_valid) g = 1;
      else if (m1_valid) g = 2;
      else g = 0;
      if (g != 0) begin mdl_own = g; mdl_age = 0; end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    run_cycle();
    reset = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its ready pulse.
  task automatic do_txn(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int sv_lat, output int busy_n,
                        output int bad_fwd, output int other_rdy);
    bit ok;
    ok = 1'b0; rd = 32'h0; sv_lat = -1; busy_n = 0; bad_fwd = 0; other_rdy = 0;
    drive_m(m, 1'b1, 1'b0, a, d, s);
    for (int k = 0; k < 40 && !ok; k++) begin
      run_cycle();
      if (smp_sv && sv_lat < 0) sv_lat = k;
      if (smp_sv) begin
        busy_n++;
        if (smp_addr !== a || smp_wstrb !== s) bad_fwd++;
      end
      if (smp_ready[1-m]) other_rdy++;
      if (smp_ready[m]) begin ok = 1'b1; rd = smp_rdata[m]; end
    end
    drive_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("txn_completes", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit cycle=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd;
    int sv_lat, busy_n, bad_fwd, other_rdy, ph, t;
    bit pend[2];
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 18; i++) begin
      ph = i % 3; t = i / 3;
      tbl[i].v0 = 1'b1; tbl[i].v1 = 1'b1;
      tbl[i].e_owner = (ph == 1) ? ((t % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      tbl[i].e_r0 = (ph == 1) && (t % 2 == 0);
      tbl[i].e_r1 = (ph == 1) && (t % 2 == 1);
    end
    reset = 1'b1; s_ready = 1'b0; s_rdata = 32'h0;
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_tmo_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_m0_count", {28'd0, m0_count}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    reset = 1'b0;

    // m0 store then load against a one-wait-state memory
    lat_cur = 1;
    do_txn(0, 32'h100, 32'hFF, 4'hF, rd, sv_lat, busy_n, bad_fwd, other_rdy);
    chk("sw_sv_latency", sv_lat, 32'd1);
    chk("sw_busy_cycles", busy_n, 32'd2);
    run_cycle();
    chk("done_owner", {30'd0, smp_owner}, 32'd0);
    chk("done_s_valid", {31'd0, smp_sv}, 32'd0);
    do_txn(0, 32'h100, 32'h0, 4'h0, rd, sv_lat, busy_n, bad_fwd, other_rdy);
    chk("lw_rdata", rd, 32'h0000_00FF);
    chk("lw_m0_count", {28'd0, m0_count}, 32'd2);
    run_cycle();

    // m1 byte-strobe write
    lat_cur = 2;
    do_txn(1, 32'h104, 32'h00AA_0000, 4'b0100, rd, sv_lat, busy_n, bad_fwd, other_rdy);
    chk("strb_forwarding", bad_fwd, 32'd0);
    chk("strb_m0_ready_quiet", other_rdy, 32'd0);
    run_cycle();

    // Contention table: grants alternate starting with m0
    do_reset();
    lat_cur = 0;
    for (int i = 0; i < 18; i++) begin
      m0_valid = tbl[i].v0; m1_valid = tbl[i].v1;
      m0_addr = 32'h10; m1_addr = 32'h20; m0_wstrb = 4'h0; m1_wstrb = 4'h0;
      run_cycle();
      chk("tbl_owner", {30'd0, smp_owner}, {30'd0, tbl[i].e_owner});
      chk("tbl_m0_ready", {31'd0, smp_ready[0]}, {31'd0, tbl[i].e_r0});
      chk("tbl_m1_ready", {31'd0, smp_ready[1]}, {31'd0, tbl[i].e_r1});
    end
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("tbl_m0_count", {28'd0, m0_count}, 32'd3);
    chk("tbl_m1_count", {28'd0, m1_count}, 32'd3);
    run_cycle();

    // Hung slave: watchdog ends the read on its 8th cycle
    do_reset();
    hang = 1'b1;
    do_txn(0, 32'h200, 32'h0, 4'h0, rd, sv_lat, busy_n, bad_fwd, other_rdy);
    chk("hang_busy_cycles", busy_n, 32'd8);
    chk("hang_rdata", rd, 32'hDEAD_BEEF);
    run_cycle();
    chk("hang_tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("hang_m0_count", {28'd0, m0_count}, 32'd0);
    hang = 1'b0; lat_cur = 0;
    do_txn(0, 32'h100, 32'h0, 4'h0, rd, sv_lat, busy_n, bad_fwd, other_rdy);
    run_cycle();
    chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Ready in the last watchdog cycle wins over the timeout
    do_reset();
    lat_cur = 7;
    do_txn(0, 32'h100, 32'h0, 4'h0, rd, sv_lat, busy_n, bad_fwd, other_rdy);
    chk("late_busy_cycles", busy_n, 32'd8);
    chk("late_rdata", rd, 32'h0000_00FF);
    run_cycle();
    chk("late_tmo_err", {31'd0, timeout_err}, 32'd0);
    chk("late_m0_count", {28'd0, m0_count}, 32'd1);

    // Reset in the middle of a hung access
    hang = 1'b1;
    drive_m(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    repeat (3) run_cycle();
    chk("mid_busy", {31'd0, smp_sv}, 32'd1);
    reset = 1'b1;
    run_cycle();
    chk("mid_no_ready", {31'd0, smp_ready[0]}, 32'd0);
    reset = 1'b0;
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    run_cycle();
    chk("mid_s_valid", {31'd0, smp_sv}, 32'd0);
    chk("mid_owner", {30'd0, smp_owner}, 32'd0);
    chk("mid_m0_count", {28'd0, m0_count}, 32'd0);
    hang = 1'b0;

    // Counter saturation
    do_reset();
    lat_cur = 0;
    for (int i = 0; i < 20; i++) begin
      do_txn(0, 32'h40, 32'h0, 4'h0, rd, sv_lat, busy_n, bad_fwd, other_rdy);
      run_cycle();
    end
    chk("sat_m0_count", {28'd0, m0_count}, 32'd15);

    // Random traffic against the reference model
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int n = 0; n < 800; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (pend[m] && smp_ready[m]) begin
          pend[m] = 1'b0;
          drive_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end else if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1;
          drive_m(m, 1'b1, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                  $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
        end
      end
      if (!smp_sv && svc_cnt == 0) begin
        lat_cur = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
        hang = ($urandom_range(0, 11) == 0);
      end
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
